// File: rtl/req_collector_if.sv
// Handshake bundle between the requestors/arbiter side and the request collector.
// The slave modport is the collector; the master modport is whoever drives strobes and grants.
interface req_collector_if #(
  parameter int unsigned CW = 3
);
  logic [3:0]        strb;
  logic [3:0]        gnt;
  logic              srv;
  logic [3:0]        req;
  logic [4*CW-1:0]   cnt;
  logic [3:0]        ovf;
  logic              err;

  modport slave (
    input  strb,
    input  gnt,
    input  srv,
    output req,
    output cnt,
    output ovf,
    output err
  );

  modport master (
    output strb,
    output gnt,
    output srv,
    input  req,
    input  cnt,
    input  ovf,
    input  err
  );
endinterface

// File: rtl/req_collector.sv
// Per-channel pending-request counters in front of a 4-channel fixed-priority arbiter.
// Strobes add work, a legal service strobe retires one item on the granted channel.
module req_collector #(
  parameter int unsigned CW = 3
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  req_collector_if.slave bus
);

  localparam logic [CW-1:0] CntMax = '1;
  localparam logic [CW-1:0] CntOne = CW'(1);

  logic [3:0][CW-1:0] cnt_q, cnt_d;
  logic [3:0]         ovf_q, ovf_d;
  logic               err_q, err_d;

  logic [3:0] req_w;
  logic [3:0] inc_w, dec_w;
  logic       gnt_onehot_w, gnt_has_work_w, srv_legal_w;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_w[i] = |cnt_q[i];
    end
  end

  // A stale grant only matters when srv is asserted; legality uses registered counts.
  always_comb begin
    gnt_onehot_w   = (bus.gnt != 4'b0000) && ((bus.gnt & (bus.gnt - 4'd1)) == 4'b0000);
    gnt_has_work_w = |(bus.gnt & req_w);
    srv_legal_w    = gnt_onehot_w & gnt_has_work_w;
    inc_w          = bus.strb;
    dec_w          = {4{bus.srv & srv_legal_w}} & bus.gnt;
    err_d          = err_q | (bus.srv & ~srv_legal_w);
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int i = 0; i < 4; i++) begin
      if (inc_w[i] && !dec_w[i]) begin
        if (cnt_q[i] == CntMax) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end else if (dec_w[i] && !inc_w[i]) begin
        cnt_d[i] = cnt_q[i] - CntOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ovf_q <= 4'b0000;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  assign bus.req = req_w;
  assign bus.cnt = cnt_q;
  assign bus.ovf = ovf_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_req_collector.sv
// Directed and randomized checks of req_collector against a counting reference model.
module tb_req_collector;
  localparam int CW   = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  int   m_cnt [4];
  bit   m_ovf [4];
  bit   m_err;

  logic [3:0] arb_gnt;
  logic [3:0] req_seq [$];

  req_collector_if #(.CW(CW)) bus ();

  req_collector #(.CW(CW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_req();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (m_cnt[i] != 0);
    return r;
  endfunction

  function automatic logic [4*CW-1:0] m_cnt_bus();
    logic [4*CW-1:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i*CW +: CW] = CW'(m_cnt[i]);
    return v;
  endfunction

  function automatic logic [3:0] m_ovf_bus();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  // Reference: count how many bits are set, look the granted channel up directly.
  task automatic model_edge(input logic [3:0] s, input logic [3:0] g, input logic v,
                            input logic r);
    bit legal;
    int gi;
    if (!r) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0;
        m_ovf[i] = 0;
      end
      m_err = 0;
      return;
    end
    gi = -1;
    for (int i = 0; i < 4; i++) if (g[i]) gi = i;
    legal = ($countones(g) == 1) && (m_cnt[gi] > 0);
    if (v && !legal) m_err = 1;
    for (int i = 0; i < 4; i++) begin
      bit inc, dec;
      inc = s[i];
      dec = v && legal && g[i];
      if (inc && !dec) begin
        if (m_cnt[i] == MAXC) m_ovf[i] = 1;
        else m_cnt[i] = m_cnt[i] + 1;
      end else if (dec && !inc) begin
        m_cnt[i] = m_cnt[i] - 1;
      end
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    n_cmp++;
    assert (bus.cnt === m_cnt_bus()) else begin
      n_bad++;
      $error("FAIL %s.cnt observed=%h expected=%h", tag, bus.cnt, m_cnt_bus());
    end
    chk4({tag, ".req"}, bus.req, m_req());
    chk4({tag, ".ovf"}, bus.ovf, m_ovf_bus());
    n_cmp++;
    assert (bus.err === m_err) else begin
      n_bad++;
      $error("FAIL %s.err observed=%b expected=%b", tag, bus.err, m_err);
    end
  endtask

  task automatic cycle(input string tag, input logic [3:0] s, input logic [3:0] g,
                       input logic v, input logic r);
    bus.strb = s;
    bus.gnt  = g;
    bus.srv  = v;
    rst_n    = r;
    @(posedge clk);
    model_edge(s, g, v, r);
    #1;
    check_all(tag);
  endtask

  function automatic logic [3:0] pri(input logic [3:0] r);
    for (int i = 3; i >= 0; i--) if (r[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  initial begin
    logic [3:0] g, nxt;
    logic       v;
    bus.strb = '0; bus.gnt = '0; bus.srv = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_ovf[i] = 0; end
    m_err = 0;

    // Reset with everything active
    cycle("rst0", 4'b1111, 4'b0001, 1'b1, 1'b0);
    cycle("rst1", 4'b1111, 4'b0001, 1'b1, 1'b0);
    chk4("rst_req_zero", bus.req, 4'b0000);
    cycle("idle", 4'b0000, 4'b0000, 1'b0, 1'b1);
    chk4("idle_req_zero", bus.req, 4'b0000);

    // Single channel
    for (int k = 0; k < 3; k++) cycle("ch2_inc", 4'b0100, 4'b0000, 1'b0, 1'b1);
    chk4("ch2_req", bus.req, 4'b0100);
    for (int k = 0; k < 3; k++) cycle("ch2_srv", 4'b0000, 4'b0100, 1'b1, 1'b1);
    chk4("ch2_done_req", bus.req, 4'b0000);
    cycle("ch2_stale", 4'b0000, 4'b0100, 1'b0, 1'b1);

    // Saturation on ch0
    for (int k = 0; k < 9; k++) cycle("sat_inc", 4'b0001, 4'b0000, 1'b0, 1'b1);
    chk4("sat_ovf", bus.ovf, 4'b0001);
    cycle("sat_incdec", 4'b0001, 4'b0001, 1'b1, 1'b1);
    cycle("sat_reset", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Simultaneous
    cycle("all_inc", 4'b1111, 4'b0000, 1'b0, 1'b1);
    chk4("all_req", bus.req, 4'b1111);
    cycle("ch3_incdec", 4'b1000, 4'b1000, 1'b1, 1'b1);

    // Illegal service cases, each from a clean start
    cycle("ill_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
    cycle("ill_prep", 4'b0101, 4'b0000, 1'b0, 1'b1);
    cycle("ill_zero", 4'b0000, 4'b0000, 1'b1, 1'b1);
    cycle("ill_rst2", 4'b0000, 4'b0000, 1'b0, 1'b0);
    cycle("ill_prep2", 4'b0110, 4'b0000, 1'b0, 1'b1);
    cycle("ill_multi", 4'b0000, 4'b0110, 1'b1, 1'b1);
    cycle("ill_rst3", 4'b0000, 4'b0000, 1'b0, 1'b0);
    cycle("ill_prep3", 4'b0001, 4'b0000, 1'b0, 1'b1);
    cycle("ill_empty", 4'b0100, 4'b0010, 1'b1, 1'b1);

    // Closed loop with a fixed-priority arbiter (ch3 highest)
    cycle("cl_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
    arb_gnt = 4'b0000;
    cycle("cl_strb", 4'b1010, arb_gnt, 1'b0, 1'b1);
    req_seq.push_back(bus.req);
    for (int k = 0; k < 8; k++) begin
      g   = arb_gnt;
      v   = |(arb_gnt & m_req());
      nxt = (m_req() != 4'b0000) ? pri(m_req()) : arb_gnt;
      cycle("cl_run", 4'b0000, g, v, 1'b1);
      arb_gnt = nxt;
      if (bus.req !== req_seq[$]) req_seq.push_back(bus.req);
    end
    n_cmp++;
    assert (req_seq.size() == 3) else begin
      n_bad++;
      $error("FAIL cl_seq_len observed=%0d expected=3", req_seq.size());
    end
    if (req_seq.size() == 3) begin
      chk4("cl_seq0", req_seq[0], 4'b1010);
      chk4("cl_seq1", req_seq[1], 4'b0010);
      chk4("cl_seq2", req_seq[2], 4'b0000);
    end

    // Randomized traffic
    cycle("rnd_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 600; k++) begin
      logic [3:0] s;
      logic       r;
      s = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 9) < 8) g = 4'(1 << $urandom_range(0, 3));
      else g = 4'($urandom);
      v = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 99) != 0);
      cycle("rnd", s, g, v, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
